// File: rtl/fp_ctrl_pkg.sv
// fp_ctrl_pkg: shared encodings for the FP issue controller
package fp_ctrl_pkg;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_MOV = 2'b11} fp_op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_EXEC = 2'b01, S_WB = 2'b10} state_e;
  typedef enum logic [1:0] {SRC_FPU = 2'b00, SRC_LOAD = 2'b01, SRC_MOVE = 2'b10} wsrc_e;
endpackage

// File: rtl/fp_scoreboard.sv
// fp_scoreboard: per-register pending-write bits with set/clear and three lookups
module fp_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_set_en,
  input  logic [4:0]  i_set_idx,
  input  logic        i_clr_en,
  input  logic [4:0]  i_clr_idx,
  input  logic [4:0]  i_qa_idx,
  input  logic [4:0]  i_qb_idx,
  input  logic [4:0]  i_qc_idx,
  output logic        o_qa,
  output logic        o_qb,
  output logic        o_qc,
  output logic [31:0] o_busy
);
  logic [31:0] r_busy, w_set, w_clr;
  assign w_set  = {31'b0, i_set_en} << i_set_idx;
  assign w_clr  = {31'b0, i_clr_en} << i_clr_idx;
  assign o_qa   = r_busy[i_qa_idx];
  assign o_qb   = r_busy[i_qb_idx];
  assign o_qc   = r_busy[i_qc_idx];
  assign o_busy = r_busy;
  // set is OR-ed in after the clear so a same-bit collision leaves it set
  always_ff @(posedge clk)
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_clr) | w_set;
endmodule

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: single-issue FP controller with scoreboard, FPU timeout and
// a shared register-file write port arbitrated between writeback and loads
module fp_issue_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [1:0]  issue_op,
  input  logic [4:0]  issue_fd,
  input  logic [4:0]  issue_fs,
  input  logic [4:0]  issue_ft,
  output logic        issue_ready,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  input  logic        fpu_done,
  input  logic        ld_valid,
  input  logic [4:0]  ld_fd,
  output logic        ld_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [1:0]  rf_wsrc,
  output logic [31:0] busy_vec,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e        r_state, w_next;
  logic [4:0]    r_fd, r_fs, r_ft;
  logic [1:0]    r_op;
  logic          r_start, r_err;
  logic [CW-1:0] r_cnt;
  logic          w_bfs, w_bft, w_bfd, w_mov_in, w_ld_hit, w_accept, w_timeout, w_wb, w_clr;
  fp_scoreboard u_sb (
    .clk(clk), .rst(rst),
    .i_set_en(w_accept), .i_set_idx(issue_fd),
    .i_clr_en(w_clr), .i_clr_idx(r_fd),
    .i_qa_idx(issue_fs), .i_qb_idx(issue_ft), .i_qc_idx(issue_fd),
    .o_qa(w_bfs), .o_qb(w_bft), .o_qc(w_bfd),
    .o_busy(busy_vec)
  );
  // mov.s has no second source, so ft neither blocks on busy nor on a pending load
  assign w_mov_in    = issue_op == OP_MOV;
  assign w_ld_hit    = ld_valid && (ld_fd == issue_fs || ld_fd == issue_fd || (!w_mov_in && ld_fd == issue_ft));
  assign issue_ready = !rst && r_state == S_IDLE && !w_bfs && !(w_bft && !w_mov_in) && !w_bfd && !w_ld_hit;
  assign w_accept    = issue_valid && issue_ready;
  assign w_timeout   = r_state == S_EXEC && !fpu_done && r_cnt == CW'(TIMEOUT - 1);
  assign w_wb        = !rst && r_state == S_WB;
  assign w_clr       = r_state == S_WB || w_timeout;
  assign ld_ready    = !rst && ld_valid && r_state != S_WB && !busy_vec[ld_fd];
  assign rf_we       = w_wb || ld_ready;
  assign rf_wa       = w_wb ? r_fd : ld_fd;
  assign rf_wsrc     = w_wb ? (r_op == OP_MOV ? SRC_MOVE : SRC_FPU) : SRC_LOAD;
  assign rf_ra1      = r_fs;
  assign rf_ra2      = r_ft;
  assign fpu_op      = r_op;
  assign fpu_start   = r_start;
  assign err         = r_err;
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (w_accept ? (w_mov_in ? S_WB : S_EXEC) : S_IDLE)
           : r_state == S_EXEC ? (fpu_done ? S_WB : (w_timeout ? S_IDLE : S_EXEC))
           : S_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk)
    if (rst) begin
      r_fd    <= '0;
      r_fs    <= '0;
      r_ft    <= '0;
      r_op    <= '0;
      r_start <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_start <= w_accept && !w_mov_in;
      if (w_accept) begin
        r_fd <= issue_fd;
        r_fs <= issue_fs;
        r_ft <= issue_ft;
        r_op <= issue_op;
      end
      r_cnt <= (r_state == S_EXEC && !fpu_done) ? r_cnt + 1'b1 : '0;
      if (w_timeout) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: directed vectors with hand-computed expectations
module tb_fp_issue_ctrl;
  logic        clk = 1'b0, rst;
  logic        issue_valid, fpu_done, ld_valid;
  logic [1:0]  issue_op;
  logic [4:0]  issue_fd, issue_fs, issue_ft, ld_fd;
  logic        issue_ready, fpu_start, ld_ready, rf_we, err;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic [1:0]  fpu_op, rf_wsrc;
  logic [31:0] busy_vec;
  int n_vec = 0, n_bad = 0;
  fp_issue_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_fd(issue_fd), .issue_fs(issue_fs), .issue_ft(issue_ft),
    .issue_ready(issue_ready), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_done(fpu_done),
    .ld_valid(ld_valid), .ld_fd(ld_fd), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wsrc(rf_wsrc),
    .busy_vec(busy_vec), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic sample;
    @(negedge clk);
  endtask
  task automatic offer(input logic v, input logic [1:0] op, input logic [4:0] fd, fs, ft);
    issue_valid = v; issue_op = op; issue_fd = fd; issue_fs = fs; issue_ft = ft;
  endtask
  task automatic load(input logic v, input logic [4:0] fd);
    ld_valid = v; ld_fd = fd;
  endtask
  initial begin
    rst = 1'b1; fpu_done = 1'b0;
    offer(1'b1, 2'b00, 5'd1, 5'd2, 5'd3);
    load(1'b1, 5'd9);
    tick;
    sample;
    chk("rst_issue_ready", issue_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    tick;
    rst = 1'b0;
    offer(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    load(1'b0, 5'd0);
    sample;
    chk("rst_busy", busy_vec, 0);
    chk("rst_err", err, 0);
    chk("rst_start", fpu_start, 0);
    chk("rst_ra1", rf_ra1, 0);
    chk("idle_ready", issue_ready, 1);
    // add.s f4,f3,f2: accept cycle 1, done cycle 4, write cycle 5, ready cycle 6
    tick;
    offer(1'b1, 2'b00, 5'd4, 5'd3, 5'd2);
    sample;
    chk("add_accept", issue_ready, 1);
    tick;
    offer(1'b0, 2'b00, 5'd4, 5'd3, 5'd2);
    sample;
    chk("add_c2_start", fpu_start, 1);
    chk("add_c2_busy", busy_vec, 32'h10);
    chk("add_c2_op", fpu_op, 0);
    chk("add_c2_ra1", rf_ra1, 3);
    chk("add_c2_ra2", rf_ra2, 2);
    chk("add_c2_we", rf_we, 0);
    tick;
    sample;
    chk("add_c3_start", fpu_start, 0);
    chk("add_c3_busy", busy_vec, 32'h10);
    tick;
    fpu_done = 1'b1;
    sample;
    chk("add_c4_we", rf_we, 0);
    chk("add_c4_busy", busy_vec, 32'h10);
    tick;
    fpu_done = 1'b0;
    sample;
    chk("add_c5_we", rf_we, 1);
    chk("add_c5_wa", rf_wa, 4);
    chk("add_c5_wsrc", rf_wsrc, 0);
    chk("add_c5_busy", busy_vec, 32'h10);
    chk("add_c5_ready", issue_ready, 0);
    tick;
    sample;
    chk("add_c6_ready", issue_ready, 1);
    chk("add_c6_busy", busy_vec, 0);
    chk("add_c6_we", rf_we, 0);
    // RAW hold of sub.s f6,f4,f1 plus a load colliding with writeback
    tick;
    offer(1'b1, 2'b00, 5'd4, 5'd3, 5'd2);
    sample;
    chk("raw_add_accept", issue_ready, 1);
    tick;
    offer(1'b1, 2'b01, 5'd6, 5'd4, 5'd1);
    sample;
    chk("raw_hold_exec", issue_ready, 0);
    tick;
    fpu_done = 1'b1;
    sample;
    chk("raw_hold_done", issue_ready, 0);
    tick;
    fpu_done = 1'b0;
    load(1'b1, 5'd7);
    sample;
    chk("raw_hold_wb", issue_ready, 0);
    chk("ld_held_wb", ld_ready, 0);
    chk("wb_wins_wa", rf_wa, 4);
    chk("wb_wins_wsrc", rf_wsrc, 0);
    tick;
    sample;
    chk("raw_release", issue_ready, 1);
    chk("ld_grant", ld_ready, 1);
    chk("ld_we", rf_we, 1);
    chk("ld_wa", rf_wa, 7);
    chk("ld_wsrc", rf_wsrc, 1);
    tick;
    offer(1'b0, 2'b01, 5'd6, 5'd4, 5'd1);
    load(1'b0, 5'd0);
    sample;
    chk("sub_start", fpu_start, 1);
    chk("sub_op", fpu_op, 1);
    chk("sub_busy", busy_vec, 32'h40);
    chk("sub_ra1", rf_ra1, 4);
    chk("sub_ra2", rf_ra2, 1);
    tick;
    fpu_done = 1'b1;
    load(1'b1, 5'd6);
    sample;
    chk("ld_busy_block", ld_ready, 0);
    tick;
    fpu_done = 1'b0;
    load(1'b0, 5'd0);
    sample;
    chk("sub_wb_we", rf_we, 1);
    chk("sub_wb_wa", rf_wa, 6);
    tick;
    sample;
    chk("sub_busy_clr", busy_vec, 0);
    // mov.s f8,f2 with ft=f9 racing a load to f9: ft must be ignored
    tick;
    offer(1'b1, 2'b11, 5'd8, 5'd2, 5'd9);
    load(1'b1, 5'd9);
    sample;
    chk("mov_accept", issue_ready, 1);
    chk("mov_ld_grant", ld_ready, 1);
    tick;
    offer(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    load(1'b0, 5'd0);
    sample;
    chk("mov_we", rf_we, 1);
    chk("mov_wa", rf_wa, 8);
    chk("mov_wsrc", rf_wsrc, 2);
    chk("mov_ra1", rf_ra1, 2);
    chk("mov_start", fpu_start, 0);
    chk("mov_busy", busy_vec, 32'h100);
    tick;
    sample;
    chk("mov_done_busy", busy_vec, 0);
    chk("mov_done_start", fpu_start, 0);
    // mul.s f5 with no fpu_done: err appears 15 cycles after entering EXEC
    tick;
    offer(1'b1, 2'b10, 5'd5, 5'd1, 5'd2);
    sample;
    chk("to_accept", issue_ready, 1);
    tick;
    offer(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 15; i++) begin
      sample;
      chk($sformatf("to_err_%0d", i), err, 0);
      chk($sformatf("to_we_%0d", i), rf_we, 0);
      chk($sformatf("to_busy_%0d", i), busy_vec, 32'h20);
      tick;
    end
    fpu_done = 1'b1;
    sample;
    chk("to_err_set", err, 1);
    chk("to_busy_clr", busy_vec, 0);
    chk("to_idle", issue_ready, 1);
    chk("to_no_we", rf_we, 0);
    tick;
    fpu_done = 1'b0;
    sample;
    chk("late_done_no_we", rf_we, 0);
    chk("err_sticky", err, 1);
    // rst pulsed mid-EXEC followed by a late fpu_done
    tick;
    offer(1'b1, 2'b00, 5'd10, 5'd1, 5'd2);
    tick;
    offer(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    sample;
    chk("rx_start", fpu_start, 1);
    tick;
    rst = 1'b1;
    sample;
    chk("rx_rst_ready", issue_ready, 0);
    tick;
    rst = 1'b0;
    fpu_done = 1'b1;
    sample;
    chk("rx_err", err, 0);
    chk("rx_busy", busy_vec, 0);
    chk("rx_we", rf_we, 0);
    chk("rx_start0", fpu_start, 0);
    chk("rx_ra1", rf_ra1, 0);
    tick;
    fpu_done = 1'b0;
    sample;
    chk("rx_late_we", rf_we, 0);
    chk("rx_late_busy", busy_vec, 0);
    // rst asserted during a mov.s writeback suppresses the write
    tick;
    offer(1'b1, 2'b11, 5'd3, 5'd1, 5'd0);
    tick;
    offer(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    sample;
    chk("rw_no_we", rf_we, 0);
    tick;
    rst = 1'b0;
    sample;
    chk("rw_busy", busy_vec, 0);
    chk("rw_we", rf_we, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
